pe_mem_unloader: RTL and testbench

//  Read-side counterpart of the PE memory load path: after sorting, walks a PE's local

---
 rtl/nanci_pkg.sv | 21 ++
 rtl/nanci_fifo2.sv | 56 +++++
 rtl/pe_mem_unloader.sv | 133 +++++++++++++
 tb/tb_pe_mem_unloader.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nanci_pkg.sv
// Shared types and helpers for the PE memory unload path and neighbour links.
package nanci_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;

  // Unloader FSM encoding (visible on the debug state output).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } unl_state_e;

  // Width of a PE index for an n x n mesh, never narrower than one bit.
  function automatic int pe_idx_w(input int n);
    int w;
    w = $clog2(n * n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/nanci_fifo2.sv
// Two-entry FIFO with registered storage. A push while full is accepted only
// when a pop happens in the same cycle, in which case occupancy is unchanged.
// Pops while empty are ignored.
module nanci_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Occupancy next-state from the accepted push/pop pair.
  always_comb begin
    count_d = count_q + 2'(do_push) - 2'(do_pop);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pe_mem_unloader.sv
// Walks a PE's local memory from address 0 to WORDS-1 and streams every word,
// tagged with its address and the PE index, on a valid/ready port.
//
// Handshake: a word transfers on a rising edge where o_valid and i_ready are
// both high; o_valid never depends on i_ready, and while o_valid=1 with
// i_ready=0 the word, address and last flag hold unchanged.
//
// Reads are credit-limited: words buffered plus a read in flight never exceed
// two, with the slot freed by this cycle's handshake counted as available so a
// ready sink sees one word per cycle.
module pe_mem_unloader
  import nanci_pkg::*;
#(
  parameter int N          = 1,
  parameter int I          = 0,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int WORDS      = 2 ** ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  output logic                    o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [ADDR_WIDTH-1:0]   o_addr,
  output logic [pe_idx_w(N)-1:0]  o_pe,
  output logic                    o_last,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [1:0]              o_dbg_state
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int FW = ADDR_WIDTH + 1 + DATA_WIDTH;
  localparam int PW = pe_idx_w(N);
  localparam logic [CW-1:0]         WORDS_C   = CW'(WORDS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);

  unl_state_e            state_q, state_d;
  logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
  logic                  in_flight_q;
  logic [ADDR_WIDTH-1:0] fl_addr_q;
  logic [FW-1:0]         push_word;
  logic [FW-1:0]         head_word;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  head_last;
  logic                  pop;
  logic                  issue;
  logic [2:0]            occupancy;

  // Returned data is tagged with the address captured when its read issued.
  assign push_word = {fl_addr_q, (fl_addr_q == LAST_ADDR), i_mem_rdata};

  nanci_fifo2 #(.W(FW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_flight_q),
    .din_i   (push_word),
    .pop_i   (pop),
    .dout_o  (head_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign o_valid   = !fifo_empty;
  assign pop       = o_valid && i_ready;
  assign {o_addr, head_last, o_data} = head_word;
  assign o_last    = head_last && o_valid;
  assign occupancy = 3'({fifo_full, !fifo_full && !fifo_empty})
                   + 3'(in_flight_q) - 3'(pop);

  // Next-state, read issue and read counter.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    issue    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d  = ST_RUN;
          rd_cnt_d = '0;
        end
      end
      ST_RUN: begin
        issue = (rd_cnt_q < WORDS_C) && (occupancy < 3'd2);
        if (issue) begin
          rd_cnt_d = rd_cnt_q + CW'(1);
          if (rd_cnt_q == WORDS_C - CW'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && head_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and read counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Track the single outstanding read and the address it targets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight_q <= 1'b0;
      fl_addr_q   <= '0;
    end else begin
      in_flight_q <= issue;
      if (issue) fl_addr_q <= rd_cnt_q[ADDR_WIDTH-1:0];
    end
  end

  assign o_mem_rd_en = issue;
  assign o_mem_addr  = issue ? rd_cnt_q[ADDR_WIDTH-1:0] : '0;
  assign o_busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign o_done      = (state_q == ST_DONE);
  assign o_pe        = PW'(I);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_pe_mem_unloader.sv
// Bench for pe_mem_unloader: an 8-word instance (N=4, I=5) fed by a memory
// holding 0x10+addr, plus a 1-word instance (ADDR_WIDTH=1) holding 0xA0+addr.
module tb_pe_mem_unloader;
  localparam int AW    = 3;
  localparam int DW    = 32;
  localparam int WORDS = 8;
  localparam int EW    = AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic          i_start = 1'b0, i_ready = 1'b0;
  logic          o_mem_rd_en, o_valid, o_last, o_busy, o_done;
  logic [AW-1:0] o_mem_addr, o_addr;
  logic [DW-1:0] i_mem_rdata, o_data;
  logic [3:0]    o_pe;
  logic [1:0]    o_dbg_state;

  pe_mem_unloader #(.N(4), .I(5), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .o_mem_rd_en(o_mem_rd_en),
    .o_mem_addr(o_mem_addr), .i_mem_rdata(i_mem_rdata), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_addr(o_addr), .o_pe(o_pe),
    .o_last(o_last), .o_busy(o_busy), .o_done(o_done), .o_dbg_state(o_dbg_state)
  );

  always @(posedge clk) if (o_mem_rd_en) i_mem_rdata <= 32'h10 + 32'(o_mem_addr);

  // ---------------- single-word DUT ----------------
  logic          s_start = 1'b0, s_ready = 1'b1;
  logic          s_rd_en, s_valid, s_last, s_busy, s_done;
  logic [0:0]    s_mem_addr, s_addr, s_pe;
  logic [DW-1:0] s_rdata, s_data;
  logic [1:0]    s_state;

  pe_mem_unloader #(.N(1), .I(0), .ADDR_WIDTH(1), .DATA_WIDTH(DW), .WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .i_start(s_start), .o_mem_rd_en(s_rd_en),
    .o_mem_addr(s_mem_addr), .i_mem_rdata(s_rdata), .o_valid(s_valid),
    .i_ready(s_ready), .o_data(s_data), .o_addr(s_addr), .o_pe(s_pe),
    .o_last(s_last), .o_busy(s_busy), .o_done(s_done), .o_dbg_state(s_state)
  );

  always @(posedge clk) if (s_rd_en) s_rdata <= 32'hA0 + 32'(s_mem_addr);

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  bit            mon_en = 1'b0;
  int            issued, popped, done_cnt;
  logic [AW:0]   rd_next;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the drain is the address sequence 0..WORDS-1 with data
  // 0x10+addr, delivered in order, with at most two reads ahead of the sink.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (o_mem_rd_en) begin
        chk("rd_addr", 64'(o_mem_addr), 64'(rd_next));
        rd_next = rd_next + 1'b1;
        issued++;
      end
      if (prev_stall) begin
        chk("stall_valid", 64'(o_valid), 64'd1);
        chk("stall_data", 64'(o_data), 64'(prev_data));
        chk("stall_addr", 64'(o_addr), 64'(prev_addr));
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_word: got addr %0h data %0h, expected no word", o_addr, o_data);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          chk("word", 64'({o_addr, o_data}), 64'(e));
          chk("last", 64'(o_last), 64'(e[EW-1 -: AW] == AW'(WORDS - 1)));
        end
        popped++;
      end
      if (o_mem_rd_en) chk("outstanding_le_2", 64'(issued - popped <= 2), 64'd1);
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      prev_addr  = o_addr;
      if (o_done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input logic st, input logic rdy);
    @(posedge clk);
    #1;
    i_start = st;
    i_ready = rdy;
    @(negedge clk);
    #1;
  endtask

  task automatic start_run(input logic rdy);
    exp_q.delete();
    for (int a = 0; a < WORDS; a++) exp_q.push_back({AW'(a), 32'h10 + 32'(a)});
    rd_next = '0; issued = 0; popped = 0; done_cnt = 0; prev_stall = 1'b0;
    mon_en = 1'b1;
    tick(1'b1, rdy);
  endtask

  task automatic finish_run(input string tag, input int ready_pct);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick(1'b0, $urandom_range(1, 100) <= ready_pct);
      if (o_done) begin seen = 1'b1; break; end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_words_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic stick(input logic st);
    @(posedge clk);
    #1;
    s_start = st;
    @(negedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rdy;
    logic          rd_en;
    logic          valid;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          last;
    logic          busy;
    logic          done;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // Ideal-sink timeline: reads on cycles 0..7, word k on cycle k+2, last
    // handshake on cycle WORDS+1, done pulse one cycle later.
    for (int k = 0; k < 12; k++) begin
      vecs[k].rdy   = 1'b1;
      vecs[k].rd_en = (k < WORDS);
      vecs[k].valid = (k >= 2) && (k <= WORDS + 1);
      vecs[k].data  = 32'h10 + 32'(k - 2);
      vecs[k].addr  = AW'(k - 2);
      vecs[k].last  = (k == WORDS + 1);
      vecs[k].busy  = (k <= WORDS + 1);
      vecs[k].done  = (k == WORDS + 2);
    end

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_rd_en", 64'(o_mem_rd_en), 0);
    chk("rst_mem_addr", 64'(o_mem_addr), 0);
    chk("rst_valid", 64'(o_valid), 0);
    chk("rst_data", 64'(o_data), 0);
    chk("rst_addr", 64'(o_addr), 0);
    chk("rst_last", 64'(o_last), 0);
    chk("rst_busy", 64'(o_busy), 0);
    chk("rst_done", 64'(o_done), 0);
    chk("rst_state", 64'(o_dbg_state), 0);
    chk("pe_index", 64'(o_pe), 5);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Table-driven ideal drain
    start_run(1'b1);
    for (int k = 0; k < 12; k++) begin
      tick(1'b0, vecs[k].rdy);
      chk($sformatf("t1_rd_en_c%0d", k), 64'(o_mem_rd_en), 64'(vecs[k].rd_en));
      chk($sformatf("t1_valid_c%0d", k), 64'(o_valid), 64'(vecs[k].valid));
      chk($sformatf("t1_busy_c%0d", k), 64'(o_busy), 64'(vecs[k].busy));
      chk($sformatf("t1_done_c%0d", k), 64'(o_done), 64'(vecs[k].done));
      if (vecs[k].valid) begin
        chk($sformatf("t1_data_c%0d", k), 64'(o_data), 64'(vecs[k].data));
        chk($sformatf("t1_addr_c%0d", k), 64'(o_addr), 64'(vecs[k].addr));
        chk($sformatf("t1_last_c%0d", k), 64'(o_last), 64'(vecs[k].last));
      end
    end
    chk("t1_words_left", 64'(exp_q.size()), 0);
    chk("t1_done_count", 64'(done_cnt), 1);

    // Ready toggling 1,0,1,0
    start_run(1'b1);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 60; k++) begin
        tick(1'b0, (k % 2) == 0);
        if (o_done) begin seen = 1'b1; break; end
      end
      chk("t2_done_seen", 64'(seen), 1);
      chk("t2_words_left", 64'(exp_q.size()), 0);
    end

    // Sink stalled for 20 cycles: exactly two reads, then resume at addr 2
    start_run(1'b0);
    for (int k = 0; k < 20; k++) tick(1'b0, 1'b0);
    chk("t3_reads_issued", 64'(issued), 2);
    chk("t3_rd_idle", 64'(o_mem_rd_en), 0);
    chk("t3_head_addr", 64'(o_addr), 0);
    tick(1'b0, 1'b1);
    chk("t3_resume_rd_en", 64'(o_mem_rd_en), 1);
    chk("t3_resume_addr", 64'(o_mem_addr), 2);
    finish_run("t3", 100);

    // Asynchronous reset after three handshakes, then a full re-drain
    start_run(1'b1);
    for (int k = 0; k < 20 && popped < 3; k++) tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("t4_rd_en", 64'(o_mem_rd_en), 0);
    chk("t4_mem_addr", 64'(o_mem_addr), 0);
    chk("t4_valid", 64'(o_valid), 0);
    chk("t4_data", 64'(o_data), 0);
    chk("t4_addr", 64'(o_addr), 0);
    chk("t4_last", 64'(o_last), 0);
    chk("t4_busy", 64'(o_busy), 0);
    chk("t4_done", 64'(o_done), 0);
    chk("t4_state", 64'(o_dbg_state), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    start_run(1'b1);
    finish_run("t4", 70);

    // i_start while busy (cycle 3) and in the DONE cycle (cycle 10) is ignored
    start_run(1'b1);
    for (int k = 0; k < 13; k++) begin
      tick(k == 3 || k == WORDS + 2, 1'b1);
      if (k == WORDS + 3) begin
        chk("t5_idle_busy", 64'(o_busy), 0);
        chk("t5_idle_rd_en", 64'(o_mem_rd_en), 0);
      end
    end
    chk("t5_done_count", 64'(done_cnt), 1);
    chk("t5_words_left", 64'(exp_q.size()), 0);

    // Randomized sink back-pressure
    for (int r = 0; r < 4; r++) begin
      start_run($urandom_range(0, 1) == 1);
      finish_run($sformatf("rand%0d", r), 30 + 20 * r);
    end
    mon_en = 1'b0;

    // Single-word instance
    stick(1'b1);
    stick(1'b0);
    chk("s_c0_rd_en", 64'(s_rd_en), 1);
    chk("s_c0_addr", 64'(s_mem_addr), 0);
    stick(1'b0);
    chk("s_c1_valid", 64'(s_valid), 0);
    chk("s_c1_rd_en", 64'(s_rd_en), 0);
    chk("s_c1_busy", 64'(s_busy), 1);
    stick(1'b0);
    chk("s_c2_valid", 64'(s_valid), 1);
    chk("s_c2_last", 64'(s_last), 1);
    chk("s_c2_data", 64'(s_data), 64'h0A0);
    chk("s_c2_addr", 64'(s_addr), 0);
    stick(1'b0);
    chk("s_c3_done", 64'(s_done), 1);
    chk("s_c3_valid", 64'(s_valid), 0);
    stick(1'b0);
    chk("s_c4_done", 64'(s_done), 0);
    chk("s_c4_busy", 64'(s_busy), 0);
    chk("s_pe", 64'(s_pe), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
